// File: rtl/dmem_pkg.sv
// Shared memop encodings and FSM state type for the data-memory responder.
package dmem_pkg;

  localparam logic [2:0] MOP_B  = 3'b000;
  localparam logic [2:0] MOP_H  = 3'b001;
  localparam logic [2:0] MOP_W  = 3'b010;
  localparam logic [2:0] MOP_BU = 3'b100;
  localparam logic [2:0] MOP_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_RESP
  } state_t;

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane steering: byte enables and write data for stores, little-endian
// extraction and sign/zero extension for loads, plus access legality flags.
module dmem_lane
  import dmem_pkg::*;
(
  input  logic        i_wr,
  input  logic [2:0]  i_memop,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misalign,
  output logic        o_illegal
);

  logic [31:0] w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_shift = i_rword >> {i_lane, 3'b000};
  assign w_byte  = w_shift[7:0];
  assign w_half  = i_lane[1] ? i_rword[31:16] : i_rword[15:0];

  // Halfword ops need an even address, word ops a word-aligned one.
  assign o_misalign = ((i_memop[1:0] == 2'b01) && i_lane[0]) ||
                      ((i_memop[1:0] == 2'b10) && (i_lane != 2'b00));

  always_comb begin
    o_be      = 4'b0000;
    o_wdata   = 32'h0;
    o_rdata   = 32'h0;
    o_illegal = 1'b0;
    if (i_wr) begin
      // Data is replicated across lanes so the byte enables alone pick the target.
      case (i_memop)
        MOP_B: begin
          o_be    = 4'b0001 << i_lane;
          o_wdata = {4{i_wdata[7:0]}};
        end
        MOP_H: begin
          o_be    = i_lane[1] ? 4'b1100 : 4'b0011;
          o_wdata = {2{i_wdata[15:0]}};
        end
        MOP_W: begin
          o_be    = 4'b1111;
          o_wdata = i_wdata;
        end
        default: o_illegal = 1'b1;
      endcase
    end else begin
      case (i_memop)
        MOP_B:   o_rdata = {{24{w_byte[7]}}, w_byte};
        MOP_H:   o_rdata = {{16{w_half[15]}}, w_half};
        MOP_W:   o_rdata = i_rword;
        MOP_BU:  o_rdata = {24'h0, w_byte};
        MOP_HU:  o_rdata = {16'h0, w_half};
        default: o_illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: one outstanding request, LAT wait states, then a
// single access cycle and a held response until the consumer takes it.
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int LAT    = 0,
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_memop,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int             IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int             AW2      = ADDR_W - 2;
  localparam logic [AW2-1:0] DEPTH_W  = AW2'(DEPTH);
  localparam logic           LAT_NZ   = (LAT > 0);
  localparam logic [3:0]     CNT_INIT = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_memop;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic [31:0]       r_mem [DEPTH];

  logic [AW2-1:0]    w_widx;
  logic [IW-1:0]     w_midx;
  logic [31:0]       w_rword;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_rdata;
  logic              w_misalign;
  logic              w_illegal;
  logic              w_oor;
  logic              w_err;
  logic              w_commit;

  assign w_widx  = r_addr[ADDR_W-1:2];
  assign w_midx  = w_widx[IW-1:0];
  assign w_rword = r_mem[w_midx];
  assign w_oor   = (w_widx >= DEPTH_W);
  assign w_err   = w_oor | w_misalign | w_illegal;

  dmem_lane u_lane (
    .i_wr       (r_wr),
    .i_memop    (r_memop),
    .i_lane     (r_addr[1:0]),
    .i_wdata    (r_wdata),
    .i_rword    (w_rword),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .o_rdata    (w_rdata),
    .o_misalign (w_misalign),
    .o_illegal  (w_illegal)
  );

  // Handshake outputs are masked by RST so nothing is offered during reset.
  assign req_ready = (r_state == ST_IDLE) && !RST;
  assign rsp_valid = (r_state == ST_RESP) && !RST;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_wr    <= req_wr;
            r_addr  <= req_addr;
            r_memop <= req_memop;
            r_wdata <= req_wdata;
            if (LAT_NZ) begin
              r_state <= ST_WAIT;
              r_cnt   <= CNT_INIT;
            end else begin
              r_state <= ST_ACCESS;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) r_state <= ST_ACCESS;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        ST_ACCESS: begin
          r_err   <= w_err;
          r_rdata <= (w_err || r_wr) ? 32'h0 : w_rdata;
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Storage is never reset; a store coinciding with RST is dropped.
  assign w_commit = !RST && (r_state == ST_ACCESS) && r_wr && !w_err;

  always_ff @(posedge CLK) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_midx][b*8 +: 8] <= w_wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: a LAT=0 and a LAT=3 instance, expected
// responses queued at issue and popped when each response appears.
module tb_dmem_resp;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_wr    [2];
  logic [31:0] req_addr  [2];
  logic [2:0]  req_memop [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  typedef struct {
    logic [31:0] rd;
    logic        er;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 CLK = ~CLK;

  dmem_resp #(.DEPTH(1024), .LAT(0), .ADDR_W(32)) u_l0 (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wr(req_wr[0]),
    .req_addr(req_addr[0]), .req_memop(req_memop[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_resp #(.DEPTH(1024), .LAT(3), .ADDR_W(32)) u_l3 (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wr(req_wr[1]),
    .req_addr(req_addr[1]), .req_memop(req_memop[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request on instance s; stall = cycles to hold rsp_ready low.
  task automatic txn(input int s, input string tag, input logic wr, input logic [31:0] addr,
                     input logic [2:0] op, input logic [31:0] wd,
                     input logic [31:0] er, input logic ee, input int stall);
    int   w;
    int   k;
    exp_t e;
    sb_q.push_back('{rd: er, er: ee});
    @(negedge CLK);
    rsp_ready[s] = (stall == 0);
    req_wr[s]    = wr;
    req_addr[s]  = addr;
    req_memop[s] = op;
    req_wdata[s] = wd;
    req_valid[s] = 1'b1;
    w = 0;
    while (!req_ready[s] && w < 20) begin
      @(negedge CLK);
      w++;
    end
    chk({tag, "_accept_timeout"}, 32'(w >= 20), 32'd0);
    @(posedge CLK);
    #1 req_valid[s] = 1'b0;
    k = 0;
    do begin
      @(posedge CLK);
      #1;
      k++;
    end while (!rsp_valid[s] && k < 40);
    chk({tag, "_latency"}, 32'(k), (s == 0) ? 32'd1 : 32'd4);
    e = sb_q.pop_front();
    chk({tag, "_rdata"}, rsp_rdata[s], e.rd);
    chk({tag, "_err"}, 32'(rsp_err[s]), 32'(e.er));
    for (int i = 0; i < stall; i++) begin
      @(posedge CLK);
      #1;
      chk({tag, "_stall_valid"}, 32'(rsp_valid[s]), 32'd1);
      chk({tag, "_stall_rdata"}, rsp_rdata[s], e.rd);
      chk({tag, "_stall_err"}, 32'(rsp_err[s]), 32'(e.er));
      chk({tag, "_stall_req_ready"}, 32'(req_ready[s]), 32'd0);
    end
    rsp_ready[s] = 1'b1;
    @(posedge CLK);
    #1;
    chk({tag, "_rsp_done"}, 32'(rsp_valid[s]), 32'd0);
    chk({tag, "_req_ready_back"}, 32'(req_ready[s]), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    RST = 1'b1;
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0; req_wr[s] = 1'b0; req_addr[s] = 32'h0;
      req_memop[s] = 3'b010; req_wdata[s] = 32'h0; rsp_ready[s] = 1'b1;
    end
    repeat (3) @(posedge CLK);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("rst_req_ready", 32'(req_ready[s]), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid[s]), 32'd0);
      chk("rst_rdata", rsp_rdata[s], 32'h0);
      chk("rst_err", 32'(rsp_err[s]), 32'd0);
    end
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("rel_req_ready0", 32'(req_ready[0]), 32'd1);
    chk("rel_req_ready1", 32'(req_ready[1]), 32'd1);

    // LAT=0: word, byte and halfword accesses
    txn(0, "sw_10",  1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0, 1'b0, 0);
    txn(0, "lw_10",  1'b0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 1'b0, 0);
    txn(0, "lb_13",  1'b0, 32'h13, 3'b000, 32'h0, 32'hFFFFFFDE, 1'b0, 0);
    txn(0, "lbu_13", 1'b0, 32'h13, 3'b100, 32'h0, 32'h000000DE, 1'b0, 0);
    txn(0, "lh_10",  1'b0, 32'h10, 3'b001, 32'h0, 32'hFFFFBEEF, 1'b0, 0);
    txn(0, "lhu_12", 1'b0, 32'h12, 3'b101, 32'h0, 32'h0000DEAD, 1'b0, 0);
    txn(0, "sb_11",  1'b1, 32'h11, 3'b000, 32'hAAAAAA55, 32'h0, 1'b0, 0);
    txn(0, "lw_sb",  1'b0, 32'h10, 3'b010, 32'h0, 32'hDEAD55EF, 1'b0, 0);
    txn(0, "lb_11",  1'b0, 32'h11, 3'b000, 32'h0, 32'h00000055, 1'b0, 0);
    txn(0, "sh_12",  1'b1, 32'h12, 3'b001, 32'hFFFF1234, 32'h0, 1'b0, 0);
    txn(0, "lw_sh",  1'b0, 32'h10, 3'b010, 32'h0, 32'h123455EF, 1'b0, 0);

    // Error cases
    txn(0, "lw_mis", 1'b0, 32'h02, 3'b010, 32'h0, 32'h0, 1'b1, 0);
    txn(0, "sw_20",  1'b1, 32'h20, 3'b010, 32'h11223344, 32'h0, 1'b0, 0);
    txn(0, "sh_mis", 1'b1, 32'h21, 3'b001, 32'h0000FFFF, 32'h0, 1'b1, 0);
    txn(0, "lw_20",  1'b0, 32'h20, 3'b010, 32'h0, 32'h11223344, 1'b0, 0);
    txn(0, "lw_oor", 1'b0, 32'h1000, 3'b010, 32'h0, 32'h0, 1'b1, 0);
    txn(0, "ld_011", 1'b0, 32'h10, 3'b011, 32'h0, 32'h0, 1'b1, 0);
    txn(0, "st_100", 1'b1, 32'h10, 3'b100, 32'h0, 32'h0, 1'b1, 0);
    txn(0, "lw_keep", 1'b0, 32'h10, 3'b010, 32'h0, 32'h123455EF, 1'b0, 0);

    // LAT=3 with a stalled consumer
    txn(1, "l3_sw44", 1'b1, 32'h44, 3'b010, 32'hCAFEF00D, 32'h0, 1'b0, 0);
    txn(1, "l3_lw44", 1'b0, 32'h44, 3'b010, 32'h0, 32'hCAFEF00D, 1'b0, 5);
    txn(1, "l3_lhu46", 1'b0, 32'h46, 3'b101, 32'h0, 32'h0000CAFE, 1'b0, 2);

    // Reset during WAIT abandons the store
    txn(1, "l3_sw40", 1'b1, 32'h40, 3'b010, 32'h0, 32'h0, 1'b0, 0);
    @(negedge CLK);
    req_wr[1] = 1'b1; req_addr[1] = 32'h40; req_memop[1] = 3'b010;
    req_wdata[1] = 32'hA5A5A5A5; req_valid[1] = 1'b1;
    @(posedge CLK);
    #1 req_valid[1] = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    chk("abort_rst_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    chk("abort_rst_req_ready", 32'(req_ready[1]), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("abort_rel_req_ready", 32'(req_ready[1]), 32'd1);
    seen = 0;
    repeat (6) begin
      @(posedge CLK);
      #1;
      if (rsp_valid[1]) seen++;
    end
    chk("abort_no_rsp", 32'(seen), 32'd0);
    txn(1, "l3_lw40", 1'b0, 32'h40, 3'b010, 32'h0, 32'h0, 1'b0, 0);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_resp.md
# dmem_resp

Data-memory responder for the single-cycle RISC-V core's load/store port, with a valid/ready handshake. It accepts one request at a time and inserts a configurable number of wait states. It performs little-endian byte/halfword/word access with sign or zero extension, and returns read data plus an error flag. It sits on the memory side of the core's data interface and replaces the ideal zero-wait data store once the core drives accesses through a handshake.

## Interface
Parameters:
- DEPTH, 1024: storage size in 32-bit words.
- LAT, 0: wait states inserted before the access cycle (0–15).
- ADDR_W, 32: request address width.

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- RST  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_wr  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_memop  in  3  RV32 funct3. Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. Stores: 000 sb, 001 sh, 010 sw.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned, out-of-range or illegal memop.

## Operation
- FSM states: IDLE, WAIT, ACCESS, RESP.
  - IDLE: req_ready=1. On req_valid, latch wr/addr/memop/wdata. Go to WAIT if LAT>0, else to ACCESS.
  - WAIT: counter loads LAT-1 on acceptance and decrements each cycle. At 0, go to ACCESS.
  - ACCESS: one cycle. Check the request, perform the write or the array read, register rsp_rdata/rsp_err, go to RESP.
  - RESP: rsp_valid=1. Hold rsp_rdata/rsp_err stable until rsp_valid&rsp_ready, then go to IDLE.
- Request fields are ignored outside IDLE. req_ready=0 in every other state, so only one request is outstanding.
- Word index is addr[ADDR_W-1:2] and lane is addr[1:0].
- Error conditions:
  - word index ≥ DEPTH;
  - lh/lhu/sh with addr[0]≠0;
  - lw/sw with addr[1:0]≠0;
  - load memop 011/110/111;
  - store memop ≥011.
- On error: no write, rsp_rdata=0, rsp_err=1.
- Store behaviour:
  - sb writes byte lane addr[1:0] with wdata[7:0].
  - sh writes lanes addr[1]*2 and +1 with wdata[15:0].
  - sw writes all lanes.
  - Other bytes of the word are unchanged.
- Load behaviour: select the addressed byte or halfword (little-endian). lb/lh sign-extend; lbu/lhu zero-extend; lw is passed through.
- Storage contents are not initialised by RST.

## Timing
- Request accepted at edge n (req_valid&req_ready sampled high). rsp_valid rises after edge n+1+LAT.
- Minimum turnaround with rsp_ready held high is LAT+3 cycles per request: accept, ACCESS, RESP, plus LAT wait cycles. A new request can be accepted at the first edge in IDLE.
- A store is committed at the edge ending ACCESS. A load issued after that store's response returns the new data.
- While RST is high:
  - state→IDLE, counter→0, rsp_valid=0, rsp_rdata=0, rsp_err=0;
  - req_ready=0 (gated by RST), 1 in the first cycle after release.
- RST during WAIT/ACCESS/RESP abandons the request; no response is issued. A store whose ACCESS cycle coincides with RST high is not written.
- rsp_ready is ignored outside RESP.

## Structure
- Package dmem_pkg:
  - memop localparams: MOP_B, MOP_H, MOP_W, MOP_BU, MOP_HU;
  - state enum: ST_IDLE, ST_WAIT, ST_ACCESS, ST_RESP.
- Sub-module dmem_lane (combinational), driven by memop, addr[1:0], wdata and read word. It produces:
  - 4-bit byte enable;
  - lane-shifted write data;
  - extended load data;
  - misalign/illegal flags.
- Top holds the FSM, wait counter, request latches, word array and response registers.

## Test plan
- LAT=0: sw 0xDEADBEEF @0x10, then lw @0x10 → rdata 0xDEADBEEF, err 0; rsp_valid one edge after acceptance.
- Byte/half extension after that store: lb @0x13 → 0xFFFFFFDE; lbu @0x13 → 0x000000DE; lh @0x10 → 0xFFFFBEEF; lhu @0x12 → 0x0000DEAD.
- Partial stores: sb 0x55 @0x11, then lw @0x10 → 0xDEAD55EF; sh 0x1234 @0x12, then lw @0x10 → 0x123455EF.
- Errors:
  - lw @0x02 → err 1, rdata 0;
  - sh @0x21, then lw @0x20 → prior value unchanged;
  - lw @DEPTH*4 → err 1;
  - load memop 011 → err 1.
- Handshake/latency: LAT=3, rsp_ready low for 5 cycles → rsp_valid rises 4 edges after acceptance; rdata/err stable while stalled; req_ready=0 until the cycle after rsp_ready.
- Reset: RST asserted in WAIT of an sw 0xA5A5A5A5 @0x40 (old 0x0) → no response; after release req_ready=1, lw @0x40 → 0x0.
